// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback controller owning the single GPR regfile write port.
//
// Arbitrates completed results from the execute unit (EXU) and the load/store
// unit (LSU) onto one registered write port. It also keeps a 32-entry pending
// scoreboard so that decode can see which destinations still await writeback.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   exu_valid/ready/rd/data   EXU result handshake
//   lsu_valid/ready/rd/data   LSU load-result handshake
//   alloc_valid, alloc_rd     decode allocates a pending destination
//   flush                     clears scoreboard and starvation state
//   rs1_addr/rs2_addr         decode query addresses
//   rs1_busy/rs2_busy         pending bit of each queried register
//   RegWEn, waddr, wdata      registered regfile write port
module wb_ctrl #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exu_valid,
   output logic            exu_ready,
   input  logic [4:0]      exu_rd,
   input  logic [XLEN-1:0] exu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   input  logic            alloc_valid,
   input  logic [4:0]      alloc_rd,
   input  logic            flush,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            RegWEn,
   output logic [4:0]      waddr,
   output logic [XLEN-1:0] wdata
);

   localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

   logic [CntW-1:0] starve_q, starve_d;
   logic [31:0]     pending_q, pending_d;
   logic            regwen_q, regwen_d;
   logic [4:0]      waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   logic            starve_at_max;
   logic            exu_gnt, lsu_gnt, accept;
   logic [4:0]      acc_rd;
   logic [XLEN-1:0] acc_data;

   assign starve_at_max = (starve_q == CntW'(STARVE_MAX));

   // LSU wins contention until the EXU has been passed over STARVE_MAX times.
   // Grants are gated by rst so that nothing is accepted while held in reset.
   always_comb begin
      exu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      if (!rst) begin
         if (lsu_valid && !(exu_valid && starve_at_max)) begin
            lsu_gnt = 1'b1;
         end else if (exu_valid) begin
            exu_gnt = 1'b1;
         end
      end
   end

   assign accept   = exu_gnt | lsu_gnt;
   assign acc_rd   = exu_gnt ? exu_rd : lsu_rd;
   assign acc_data = exu_gnt ? exu_data : lsu_data;

   assign exu_ready = exu_gnt;
   assign lsu_ready = lsu_gnt;

   always_comb begin
      starve_d = starve_q;
      if (flush || !exu_valid || exu_gnt) begin
         starve_d = '0;
      end else if (lsu_gnt && !starve_at_max) begin
         starve_d = starve_q + CntW'(1);
      end
   end

   // Write port: x0 results are consumed but never raise the write enable.
   always_comb begin
      regwen_d = accept && (acc_rd != 5'd0);
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      if (accept) begin
         waddr_d = acc_rd;
         wdata_d = acc_data;
      end
   end

   // Clear is applied before set so a same-cycle re-allocation keeps the bit.
   always_comb begin
      pending_d = pending_q;
      if (flush) begin
         pending_d = '0;
      end else begin
         if (accept) begin
            pending_d[acc_rd] = 1'b0;
         end
         if (alloc_valid) begin
            pending_d[alloc_rd] = 1'b1;
         end
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q  <= '0;
         pending_q <= '0;
         regwen_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         starve_q  <= starve_d;
         pending_q <= pending_d;
         regwen_q  <= regwen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   // Read from the registered bitmap: a clear in the accept cycle is not bypassed.
   assign rs1_busy = pending_q[rs1_addr];
   assign rs2_busy = pending_q[rs2_addr];

   assign RegWEn = regwen_q;
   assign waddr  = waddr_q;
   assign wdata  = wdata_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: table-driven bench for wb_ctrl plus hand-written async reset sequence.
// Each vector is driven just after a falling edge and checked 1 ns later. The
// registered expectations in a vector describe the result of the previous vector.
module tb_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid, lsu_valid, alloc_valid, flush;
   logic        exu_ready, lsu_ready, rs1_busy, rs2_busy, RegWEn;
   logic [4:0]  exu_rd, lsu_rd, alloc_rd, rs1_addr, rs2_addr, waddr;
   logic [31:0] exu_data, lsu_data, wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_ctrl #(.XLEN(32), .STARVE_MAX(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .exu_valid  (exu_valid),
      .exu_ready  (exu_ready),
      .exu_rd     (exu_rd),
      .exu_data   (exu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .alloc_valid(alloc_valid),
      .alloc_rd   (alloc_rd),
      .flush      (flush),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .RegWEn     (RegWEn),
      .waddr      (waddr),
      .wdata      (wdata)
   );

   typedef struct {
      logic        ev;
      logic [4:0]  erd;
      logic [31:0] edat;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldat;
      logic        av;
      logic [4:0]  ard;
      logic        fl;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        x_er;
      logic        x_lr;
      logic        x_b1;
      logic        x_b2;
      logic        x_we;
      logic [4:0]  x_wa;
      logic [31:0] x_wd;
      logic        chk_w;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic ev, input logic [4:0] erd, input logic [31:0] edat,
      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
      input logic av, input logic [4:0] ard, input logic fl,
      input logic [4:0] r1, input logic [4:0] r2,
      input logic x_er, input logic x_lr, input logic x_b1, input logic x_b2,
      input logic x_we, input logic [4:0] x_wa, input logic [31:0] x_wd,
      input logic chk_w);
      vec_t v;
      v.ev = ev;   v.erd = erd; v.edat = edat;
      v.lv = lv;   v.lrd = lrd; v.ldat = ldat;
      v.av = av;   v.ard = ard; v.fl = fl;
      v.r1 = r1;   v.r2 = r2;
      v.x_er = x_er; v.x_lr = x_lr; v.x_b1 = x_b1; v.x_b2 = x_b2;
      v.x_we = x_we; v.x_wa = x_wa; v.x_wd = x_wd; v.chk_w = chk_w;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      exu_valid   = v.ev; exu_rd = v.erd; exu_data = v.edat;
      lsu_valid   = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
      alloc_valid = v.av; alloc_rd = v.ard; flush = v.fl;
      rs1_addr    = v.r1; rs2_addr = v.r2;
   endtask

   initial begin
      vec_t idle;
      idle = mk(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0);

      //        ev erd edat          lv lrd ldat       av ard fl r1 r2  er lr b1 b2 we wa wd  chk
      vq.push_back(mk(0,0,0,            0,0,0,        0,0,0, 0,0,  0,0,0,0, 0,0,0,1));
      vq.push_back(mk(1,5,32'hDEADBEEF, 0,0,0,        0,0,0, 0,0,  1,0,0,0, 0,0,0,1));
      vq.push_back(mk(0,0,0,            0,0,0,        0,0,0, 0,0,  0,0,0,0, 1,5,32'hDEADBEEF,1));
      vq.push_back(mk(0,0,0,            0,0,0,        0,0,0, 0,0,  0,0,0,0, 0,5,32'hDEADBEEF,1));
      // x0 result: accepted, never written, never pending
      vq.push_back(mk(1,0,1,            0,0,0,        0,0,0, 0,0,  1,0,0,0, 0,0,0,0));
      vq.push_back(mk(0,0,0,            0,0,0,        0,0,0, 0,0,  0,0,0,0, 0,0,0,0));
      vq.push_back(mk(0,0,0,            1,9,32'h1234, 0,0,0, 0,0,  0,1,0,0, 0,0,0,0));
      vq.push_back(mk(0,0,0,            0,0,0,        0,0,0, 0,0,  0,0,0,0, 1,9,32'h1234,1));
      // contention for 7 cycles: LSU x4, EXU, LSU x2
      for (int i = 0; i < 7; i++) begin
         logic xe;
         xe = (i == 4);
         vq.push_back(mk(1,4,32'h44, 1,3,32'h33, 0,0,0, 0,0, xe,!xe,0,0,
                         (i != 0), (i == 5) ? 5'd4 : 5'd3, (i == 5) ? 32'h44 : 32'h33,
                         (i != 0)));
      end
      vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,  0,0,0,0, 1,3,32'h33,1));
      // contention again: starve count was cleared, so 4 LSU grants before EXU
      for (int i = 0; i < 5; i++) begin
         vq.push_back(mk(1,4,32'h44, 1,3,32'h33, 0,0,0, 0,0, (i == 4),(i != 4),0,0,
                         (i != 0), 5'd3, 32'h33, (i != 0)));
      end
      vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,  0,0,0,0, 1,4,32'h44,1));
      // scoreboard
      vq.push_back(mk(0,0,0, 0,0,0,        1,7,0, 7,0,  0,0,0,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0,0,        0,0,0, 7,0,  0,0,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0,0,        0,0,0, 7,0,  0,0,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 1,7,32'h77,   0,0,0, 7,0,  0,1,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0,0,        0,0,0, 7,0,  0,0,0,0, 1,7,32'h77,1));
      vq.push_back(mk(0,0,0, 0,0,0,        1,7,0, 7,0,  0,0,0,0, 0,0,0,0));
      vq.push_back(mk(1,7,32'h70, 0,0,0,   1,7,0, 7,0,  1,0,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0,0,        0,0,0, 7,0,  0,0,1,0, 1,7,32'h70,1));
      // flush: pending {2,7,9}; flush with alloc 9 and an EXU accept
      vq.push_back(mk(0,0,0, 0,0,0,        1,2,0, 7,2,  0,0,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0,0,        1,9,0, 2,9,  0,0,1,0, 0,0,0,0));
      vq.push_back(mk(1,12,32'hF1, 0,0,0,  1,9,1, 2,9,  1,0,1,1, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0,0,        0,0,0, 2,9,  0,0,0,0, 1,12,32'hF1,1));
      vq.push_back(mk(0,0,0, 0,0,0,        1,0,0, 7,0,  0,0,0,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0,0,        0,0,0, 0,0,  0,0,0,0, 0,0,0,0));
      // flush clears starve count: LSU,LSU,LSU+flush, then 4 more LSU before EXU
      for (int i = 0; i < 8; i++) begin
         vq.push_back(mk(1,4,32'h44, 1,3,32'h33, 0,0,(i == 2), 0,0, (i == 7),(i != 7),0,0,
                         (i != 0), 5'd3, 32'h33, (i != 0)));
      end
      vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,  0,0,0,0, 1,4,32'h44,1));

      // reset state, including readies held low while rst is high
      rst = 1'b1;
      drive(idle);
      exu_valid = 1'b1;
      lsu_valid = 1'b1;
      #2;
      check("rst_exu_ready", {31'd0, exu_ready}, 32'd0);
      check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
      check("rst_regwen", {31'd0, RegWEn}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      drive(idle);
      rst = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i]);
         #1;
         check($sformatf("v%0d_exu_ready", i), {31'd0, exu_ready}, {31'd0, vq[i].x_er});
         check($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vq[i].x_lr});
         check($sformatf("v%0d_rs1_busy", i),  {31'd0, rs1_busy},  {31'd0, vq[i].x_b1});
         check($sformatf("v%0d_rs2_busy", i),  {31'd0, rs2_busy},  {31'd0, vq[i].x_b2});
         check($sformatf("v%0d_regwen", i),    {31'd0, RegWEn},    {31'd0, vq[i].x_we});
         if (vq[i].chk_w) begin
            check($sformatf("v%0d_waddr", i), {27'd0, waddr}, {27'd0, vq[i].x_wa});
            check($sformatf("v%0d_wdata", i), wdata, vq[i].x_wd);
         end
      end

      // async reset between edges while a write is on the port
      @(negedge clk);
      drive(idle);
      alloc_valid = 1'b1; alloc_rd = 5'd5; rs1_addr = 5'd5;
      exu_valid = 1'b1; exu_rd = 5'd6; exu_data = 32'hAB;
      @(posedge clk);
      #1;
      alloc_valid = 1'b0;
      check("ar_pre_regwen", {31'd0, RegWEn}, 32'd1);
      check("ar_pre_busy", {31'd0, rs1_busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("ar_regwen", {31'd0, RegWEn}, 32'd0);
      check("ar_busy", {31'd0, rs1_busy}, 32'd0);
      check("ar_waddr", {27'd0, waddr}, 32'd0);
      check("ar_wdata", wdata, 32'd0);
      check("ar_exu_ready", {31'd0, exu_ready}, 32'd0);
      // exu_valid held through a reset edge: that result must be dropped
      @(posedge clk);
      #1;
      check("ar_held_regwen", {31'd0, RegWEn}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exu_valid = 1'b0;
      @(posedge clk);
      #1;
      check("ar_post_regwen", {31'd0, RegWEn}, 32'd0);
      check("ar_post_waddr", {27'd0, waddr}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
